// File: rtl/phy_tx_serializer.sv
// phy_tx_serializer: byte-to-serial transmit stage (MSB-first, one bit per clk_32f).
// Sends a comma preamble after reset, then buffered data bytes or idle filler.
// Optional build macro PHY_TX_BYTECNT_EN adds the tx_bytes data-byte counter.
module phy_tx_serializer #(
    parameter int unsigned SYNC_COMMAS = 4,
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter logic [7:0]  IDLE        = 8'h7C
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        data_out,
    output logic        byte_start,
    output logic        sync_done
`ifdef PHY_TX_BYTECNT_EN
    ,
    output logic [15:0] tx_bytes
`endif
);

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BIT_CNT_W   = 3;
    localparam int unsigned COMMA_CNT_W = 4;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [BYTE_W-1:0]        r_shreg;
    logic [BIT_CNT_W-1:0]     r_bitcnt;
    logic [COMMA_CNT_W-1:0]   r_commacnt;
    logic [BYTE_W-1:0]        r_hold;
    logic                     r_hold_full;
    logic                     r_sync_done;

    logic                     w_bnd;
    logic                     w_last_comma;
    logic                     w_comma_load;
    logic                     w_load_hold;
    logic                     w_ready;
    logic                     w_accept;
    logic [BYTE_W-1:0]        w_next_byte;

    assign w_bnd        = (r_bitcnt == BIT_CNT_W'(7));
    assign w_last_comma = (r_commacnt == COMMA_CNT_W'(SYNC_COMMAS - 1));
    // Async reset already clears every flop, so accept need not be gated by reset.
    assign w_accept     = valid_in && w_ready;

    // State register
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave SYNC on the edge that loads the last preamble comma
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_SYNC && w_bnd && w_last_comma) begin
            w_state_nxt = ST_DATA;
        end
    end

    // Per-state outputs: byte to load at the boundary and buffer readiness
    always_comb begin
        w_next_byte  = COMMA;
        w_comma_load = 1'b0;
        w_load_hold  = 1'b0;
        w_ready      = !r_hold_full;
        case (r_state)
            ST_SYNC: begin
                w_next_byte  = COMMA;
                w_comma_load = w_bnd;
            end
            ST_DATA: begin
                w_next_byte = r_hold_full ? r_hold : IDLE;
                w_load_hold = w_bnd && r_hold_full;
                w_ready     = !r_hold_full || w_bnd;
            end
            default: begin
                w_next_byte = COMMA;
            end
        endcase
    end

    // Shift register and bit counter; reload at every byte boundary
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_shreg  <= '0;
            r_bitcnt <= BIT_CNT_W'(7);
        end else if (w_bnd) begin
            r_shreg  <= w_next_byte;
            r_bitcnt <= '0;
        end else begin
            r_shreg  <= {r_shreg[BYTE_W-2:0], 1'b0};
            r_bitcnt <= r_bitcnt + BIT_CNT_W'(1);
        end
    end

    // Preamble comma counter and sync flag
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_commacnt  <= '0;
            r_sync_done <= 1'b0;
        end else if (w_comma_load) begin
            r_commacnt <= r_commacnt + COMMA_CNT_W'(1);
            if (w_last_comma) begin
                r_sync_done <= 1'b1;
            end
        end
    end

    // One-entry holding buffer; a same-edge accept refills it as it drains
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
        end else if (w_load_hold) begin
            r_hold_full <= 1'b0;
        end
    end

`ifdef PHY_TX_BYTECNT_EN
    localparam int unsigned BYTE_CNT_W = 16;
    logic [BYTE_CNT_W-1:0] r_tx_bytes;

    // Count data bytes moved from the buffer onto the line (wraps)
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_tx_bytes <= '0;
        end else if (w_load_hold) begin
            r_tx_bytes <= r_tx_bytes + BYTE_CNT_W'(1);
        end
    end

    assign tx_bytes = r_tx_bytes;
`endif

    assign data_out   = r_shreg[BYTE_W-1];
    assign byte_start = (r_bitcnt == '0) && reset;
    assign ready_out  = w_ready && reset;
    assign sync_done  = r_sync_done;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Self-checking bench for phy_tx_serializer: table-driven slot vectors plus
// hand-written back-to-back, gap and mid-byte reset sequences.
module tb_phy_tx_serializer;

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        data_out;
    logic        byte_start;
    logic        sync_done;
`ifdef PHY_TX_BYTECNT_EN
    logic [15:0] tx_bytes;
`endif

    phy_tx_serializer dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .byte_start (byte_start),
        .sync_done  (sync_done)
`ifdef PHY_TX_BYTECNT_EN
        ,
        .tx_bytes   (tx_bytes)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    int checks = 0;
    int errors = 0;

    // Line monitor: reassembles bytes aligned on byte_start, checks spacing
    logic [7:0] line_q[$];
    logic [7:0] mon_byte = 8'h00;
    int         mon_cnt   = 0;
    int         since     = 0;
    bit         mon_first = 1'b1;
    int         gap_err   = 0;

    always @(negedge clk_32f) begin
        if (!reset) begin
            mon_cnt   <= 0;
            mon_first <= 1'b1;
            since     <= 0;
        end else if (byte_start) begin
            if (!mon_first && since != 8) gap_err <= gap_err + 1;
            mon_first <= 1'b0;
            since     <= 1;
            mon_byte  <= {7'b0, data_out};
            mon_cnt   <= 1;
        end else begin
            since <= since + 1;
            if (mon_cnt > 0) begin
                mon_byte <= {mon_byte[6:0], data_out};
                if (mon_cnt == 7) begin
                    line_q.push_back({mon_byte[6:0], data_out});
                    mon_cnt <= 0;
                end else begin
                    mon_cnt <= mon_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_32f); #1;
        reset    = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        line_q.delete();
        reset = 1'b1;
    endtask

    task automatic wait_slot();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_32f);
            if (byte_start) begin
                ok = 1'b1;
                break;
            end
        end
        chk("slot_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_sync();
        bit ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_32f);
            if (sync_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("sync_timeout", 32'(ok), 32'd1);
    endtask

    // Called just after a rising edge; holds valid_in until the byte is taken
    task automatic send_byte(input logic [7:0] d);
        bit ok = 1'b0;
        bit r;
        valid_in = 1'b1;
        data_in  = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_32f);
            r = ready_out;
            @(posedge clk_32f); #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        valid_in = 1'b0;
        chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_bytes(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_32f);
            if (line_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bytes_timeout", 32'(ok), 32'd1);
    endtask

    task automatic check_stream(input string name, input logic [7:0] e[$]);
        for (int i = 0; i < e.size(); i++) begin
            if (i < line_q.size()) chk($sformatf("%s[%0d]", name, i), 32'(line_q[i]), 32'(e[i]));
            else                   chk($sformatf("%s[%0d]_missing", name, i), 32'd0, 32'd1);
        end
    endtask

    typedef struct {
        bit         send;
        logic [7:0] din;
        logic [7:0] exp_line;
        logic       exp_sync;
        logic       exp_ready;
    } vec_t;

    vec_t       tbl[13];
    logic [7:0] e[$];

    initial begin
        // Per byte slot after reset: byte offered in that slot, expected line byte,
        // sync_done and ready_out at the slot's first bit.
        tbl[0]  = '{1'b1, 8'hA5, 8'hBC, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 8'hBC, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 8'hBC, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 8'hBC, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 8'hA5, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 8'h55, 8'h7C, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 8'hFF, 8'h55, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 8'h00, 8'hFF, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 8'h7C, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 8'h80, 8'h7C, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 8'h7C, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(negedge clk_32f);
        chk("rst_data_out",   32'(data_out),   32'd0);
        chk("rst_byte_start", 32'(byte_start), 32'd0);
        chk("rst_sync_done",  32'(sync_done),  32'd0);
        chk("rst_ready_out",  32'(ready_out),  32'd0);
`ifdef PHY_TX_BYTECNT_EN
        chk("rst_tx_bytes",   32'(tx_bytes),   32'd0);
`endif

        // Table-driven slots: preamble, byte buffered in SYNC, singles and idles
        do_reset();
        for (int i = 0; i < 13; i++) begin
            wait_slot();
            chk($sformatf("tbl%0d_sync", i),  32'(sync_done), 32'(tbl[i].exp_sync));
            chk($sformatf("tbl%0d_ready", i), 32'(ready_out), 32'(tbl[i].exp_ready));
            if (tbl[i].send) begin
                @(posedge clk_32f); #1;
                send_byte(tbl[i].din);
            end
        end
        wait_bytes(13);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("tbl%0d_line", i), 32'(line_q[i]), 32'(tbl[i].exp_line));
        end

        // Back-to-back bytes with valid_in held high
        do_reset();
        wait_sync();
        @(posedge clk_32f); #1;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        wait_bytes(8);
        e = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h01, 8'h02, 8'h03, 8'h7C};
        check_stream("b2b", e);

        // Gap of 20 cycles between two bytes is filled with idles
        do_reset();
        wait_sync();
        @(posedge clk_32f); #1;
        send_byte(8'h55);
        repeat (20) @(posedge clk_32f);
        #1;
        send_byte(8'hAA);
        wait_bytes(8);
        e = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h55, 8'h7C, 8'hAA, 8'h7C};
        check_stream("gap", e);

        // Reset at bit 3 of 0xF0 with another byte buffered
        do_reset();
        wait_sync();
        @(posedge clk_32f); #1;
        send_byte(8'hF0);
        wait_slot();
        @(posedge clk_32f); #1;
        send_byte(8'h99);
        @(posedge clk_32f); #1;
        chk("mid_bit3_of_f0", 32'(data_out), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_data_out",   32'(data_out),   32'd0);
        chk("mid_rst_byte_start", 32'(byte_start), 32'd0);
        chk("mid_rst_sync_done",  32'(sync_done),  32'd0);
        chk("mid_rst_ready_out",  32'(ready_out),  32'd0);
        repeat (2) @(posedge clk_32f);
        #1;
        line_q.delete();
        reset = 1'b1;
        wait_bytes(6);
        e = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h7C, 8'h7C};
        check_stream("mid_rst", e);

`ifdef PHY_TX_BYTECNT_EN
        // Only data bytes are counted, not commas or idles
        do_reset();
        @(negedge clk_32f);
        chk("cnt_after_reset", 32'(tx_bytes), 32'd0);
        wait_sync();
        @(posedge clk_32f); #1;
        for (int i = 0; i < 20; i++) send_byte(8'(i + 16));
        wait_bytes(26);
        chk("cnt_20_bytes", 32'(tx_bytes), 32'd20);
`endif

        chk("byte_spacing", 32'(gap_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
